serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/fulladder.sv | 16 +
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder used as the per-bit datapath of serial_adder.
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: accepts a+b+cin, produces sum/cout WIDTH cycles later.
// Optional signed-overflow output `ovf` when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_cat;

    fulladder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // On the final bit this is the complete sum: new MSB over the WIDTH-1 bits already shifted in.
    assign w_sum_cat = {w_s, r_sum_sh};

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + CW'(1);
                    r_sum_sh <= w_sum_cat[WIDTH-1:1];
                    if (w_last) begin
                        r_sum  <= w_sum_cat;
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vectors, expected-queue
// scoreboard popped by an output monitor, plus latency/hold/reset/throughput checks.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // expected entry: {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: pops one expected result per output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [W+1:0] e;
            check("in_ready_while_out_valid", in_ready, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e[W-1:0]);
                check("cout", cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", ovf, e[W+1]);
`endif
            end
        end
    end

    // driver tasks
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic push, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_wait_in_ready", 0, 1);
        a = ta;
        b = tb_;
        cin = tc;
        in_valid = 1'b1;
        if (push) exp_q.push_back({e_ovf, e_cout, e_sum});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic         vc[4];
    logic [W-1:0] es[4];
    logic         ec[4];
    logic         eo[4];

    initial begin : stim
        int accepts;
        int cyc;
        int last_acc;
        logic was_ready;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // 3C+5A: latency must be exactly W cycles after acceptance
        send(8'h3C, 8'h5A, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            check($sformatf("latency_out_valid_c%0d", i), out_valid, (i == W) ? 1 : 0);
        end
        drain();

        send(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        drain();
        send(8'h7F, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
        drain();

        // hold in DONE with out_ready low; stray in_valid pulses must be ignored
        out_ready = 1'b0;
        send(8'hA5, 8'h0F, 1'b1, 1'b1, 8'hB5, 1'b0, 1'b0);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (i < W) check("in_ready_run", in_ready, 0);
            in_valid = (i % 2 == 1);
            a = 8'h11;
            b = 8'h11;
            cin = 1'b1;
        end
        check("done_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_sum", sum, 8'hB5);
            check("hold_cout", cout, 0);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset on the 4th RUN cycle aborts without a result
        send(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_idle", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready_after", in_ready, 1);
        check("abort_no_result", out_valid, 0);
        send(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        drain();

        // back-to-back: one result every W+2 cycles
        va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0; es[0] = 8'h46; ec[0] = 1'b0; eo[0] = 1'b0;
        va[1] = 8'hC8; vb[1] = 8'h64; vc[1] = 1'b0; es[1] = 8'h2C; ec[1] = 1'b1; eo[1] = 1'b0;
        va[2] = 8'h80; vb[2] = 8'h80; vc[2] = 1'b1; es[2] = 8'h01; ec[2] = 1'b1; eo[2] = 1'b1;
        va[3] = 8'h55; vb[3] = 8'hAA; vc[3] = 1'b1; es[3] = 8'h00; ec[3] = 1'b1; eo[3] = 1'b0;
        out_ready = 1'b1;
        accepts = 0;
        cyc = 0;
        last_acc = 0;
        a = va[0];
        b = vb[0];
        cin = vc[0];
        in_valid = 1'b1;
        for (int c = 0; c < 200 && accepts < 4; c++) begin
            was_ready = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (was_ready) begin
                exp_q.push_back({eo[accepts], ec[accepts], es[accepts]});
                if (accepts > 0) check("b2b_period", cyc - last_acc, W + 2);
                last_acc = cyc;
                accepts++;
                if (accepts < 4) begin
                    a = va[accepts];
                    b = vb[accepts];
                    cin = vc[accepts];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", accepts, 4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
